pcileech_ft601_emu: RTL
=======================

Name: pcileech_ft601_emu

Overview:
- Synthesizable device-side model of the FT601 245-synchronous FIFO bus: the chip end of the protocol that pcileech_com masters.
- Used in self-test builds: replaces the FT601 pads so the full com/fifo/PCIe path runs in loopback without a USB host.
- Internal logic injects host-to-FPGA words (appear on ft_rxf_n/read bursts).
- Internal logic captures FPGA-to-host words accepted via ft_wr_n.

Parameters:
- DEPTH_LOG2, 9: log2 word depth of each internal buffer (RX and TX).
- TX_BURST, 1024: words accepted on the write side before a forced ft_txe_n gap.
- TX_GAP, 8: cycles ft_txe_n is forced high after a TX_BURST.

Ports:
- clk  in  1  single clock; bus and buffers share it.
- rst  in  1  synchronous, active-high reset.
- ft_data_i  in  32  data driven by FPGA master (write direction).
- ft_be_i  in  4  byte enables from master.
- ft_data_o  out  32  data driven toward master (read direction).
- ft_be_o  out  4  byte enables toward master.
- ft_data_oe  out  1  1 = emulator owns the bus.
- ft_rxf_n  out  1  0 = RX data available.
- ft_txe_n  out  1  0 = write space available.
- ft_wr_n  in  1  master write strobe.
- ft_rd_n  in  1  master read strobe.
- ft_oe_n  in  1  master output-enable request.
- inj_data  in  32  word to place in RX buffer.
- inj_valid  in  1  injection valid.
- inj_ready  out  1  = RX buffer not full.
- cap_data  out  36  captured {be[3:0], data[31:0]}, head of TX buffer.
- cap_valid  out  1  TX buffer non-empty.
- cap_ready  in  1  pops TX head when cap_valid & cap_ready.
- err_cnt  out  16  saturating protocol-violation count.

Behaviour:
- Reset values:
  - ft_rxf_n=1, ft_txe_n=1, ft_data_oe=0, ft_data_o=0, ft_be_o=0.
  - cap_valid=0, inj_ready=0, err_cnt=0.
  - Buffers emptied, burst/gap counters 0, FSM=IDLE.
- First cycle after reset: ft_txe_n=0, inj_ready=1.
- Reset mid-burst: immediately drops ft_data_oe and discards all buffered words.
- RX buffer:
  - Push on inj_valid & inj_ready.
  - ft_rxf_n is registered = (RX count after this cycle's push/pop == 0). First injected word at cycle N → ft_rxf_n=0 at N+1.
  - Simultaneous push and pop: count unchanged.
- FSM states:
  - IDLE:
    - ft_data_oe=0.
    - ft_oe_n=0 & ft_rxf_n=0 → RD_TA.
    - ft_oe_n=0 & ft_rxf_n=1 → stays IDLE.
  - RD_TA (one-cycle turnaround):
    - ft_data_oe=1, ft_data_o=RX head, ft_be_o=4'hF; no pop.
    - → READ.
  - READ:
    - ft_data_oe=1.
    - ft_rd_n=0 & RX non-empty: pop; next head is presented on the following cycle (1 word/cycle, zero bubbles).
    - Last word popped: ft_rxf_n=1 next cycle; later ft_rd_n=0 pops nothing, ft_data_o holds the last value.
    - ft_oe_n=1 → IDLE; ft_data_oe=0 the next cycle.
- Write side:
  - Word accepted only when ft_wr_n=0, ft_txe_n=0 (as currently driven) and FSM=IDLE.
  - Accepted word pushes {ft_be_i, ft_data_i} to TX.
  - ft_txe_n registered = TX full-after-update OR gap active.
  - Burst counter counts accepted words. On reaching TX_BURST: counter clears, ft_txe_n=1 for exactly TX_GAP cycles, then reverts to the full check.
- Violations (err_cnt +1 each, saturates at 16'hFFFF):
  - ft_wr_n=0 while ft_txe_n=1: word dropped.
  - ft_wr_n=0 while FSM≠IDLE: word dropped.
  - ft_oe_n=0 and ft_wr_n=0 same cycle in IDLE: write wins, oe ignored that cycle.
  - ft_rd_n=0 while FSM=IDLE or RD_TA: no pop.
- cap path: standard valid/ready; cap_data stable while cap_valid & !cap_ready.

Test Plan:
- Reset release: rxf_n=1, txe_n=0 and inj_ready=1 on cycle 1; err_cnt=0.
- Inject 0x11111111, 0x22222222, 0x33333333 → rxf_n=0 one cycle after first accept.
  - Master oe_n=0, then rd_n=0 for 3 cycles → data_oe=1 after the turnaround cycle; words appear in order.
  - rxf_n=1 the cycle after the third pop; err_cnt=0.
- Master writes 1030 words (be=4'hF, data=index) with cap_ready=1 → txe_n=1 for exactly 8 cycles after word 1024.
  - cap sees 0..1029 in order.
- cap_ready=0, write 512 words (DEPTH_LOG2=9) → txe_n=1 after word 512.
  - 513th wr_n=0 dropped, err_cnt=1.
  - One cap pop → txe_n=0 next cycle.
- Inject and read simultaneously for 100 cycles at 1 word/cycle → RX count constant, no data loss, rxf_n stays 0.
- Assert rst mid-read burst → data_oe=0 and rxf_n=1 the next cycle.
  - After release, master read of the previously buffered words yields none (buffers empty).

Source files
------------

// File: rtl/pcileech_ft601_emu_if.sv
// FT601 245-synchronous FIFO bus bundle between the pcileech_com master and the device-side emulator.
interface pcileech_ft601_emu_if;
    logic [31:0] ft_data_i;
    logic [3:0]  ft_be_i;
    logic [31:0] ft_data_o;
    logic [3:0]  ft_be_o;
    logic        ft_data_oe;
    logic        ft_rxf_n;
    logic        ft_txe_n;
    logic        ft_wr_n;
    logic        ft_rd_n;
    logic        ft_oe_n;

    modport master (
        output ft_data_i, ft_be_i, ft_wr_n, ft_rd_n, ft_oe_n,
        input  ft_data_o, ft_be_o, ft_data_oe, ft_rxf_n, ft_txe_n
    );

    modport slave (
        input  ft_data_i, ft_be_i, ft_wr_n, ft_rd_n, ft_oe_n,
        output ft_data_o, ft_be_o, ft_data_oe, ft_rxf_n, ft_txe_n
    );
endinterface

// File: rtl/pcileech_ft601_emu.sv
// Device-side FT601 model: injected words are served on read bursts, master writes are captured,
// and protocol misuse is counted so loopback self-tests run without a USB host.
module pcileech_ft601_emu #(
    parameter int DEPTH_LOG2 = 9,
    parameter int TX_BURST   = 1024,
    parameter int TX_GAP     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    pcileech_ft601_emu_if.slave     ft,
    input  logic [31:0]             inj_data,
    input  logic                    inj_valid,
    output logic                    inj_ready,
    output logic [35:0]             cap_data,
    output logic                    cap_valid,
    input  logic                    cap_ready,
    output logic [15:0]             err_cnt
);
    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int CNT_W   = DEPTH_LOG2 + 1;
    localparam int BURST_W = $clog2(TX_BURST + 1);
    localparam int GAP_W   = $clog2(TX_GAP + 1) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RD_TA = 2'd1, READ = 2'd2} state_t;

    state_t state_r, state_next_s;

    logic [31:0]           rx_mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] rx_wr_ptr_r, rx_rd_ptr_r, rx_rd_ptr_next_s;
    logic [CNT_W-1:0]      rx_count_r, rx_count_next_s;
    logic                  rx_push_s, rx_pop_s;
    logic [31:0]           rx_head_next_s;

    logic [35:0]           tx_mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wr_ptr_r, tx_rd_ptr_r;
    logic [CNT_W-1:0]      tx_count_r, tx_count_next_s;
    logic                  tx_push_s, tx_pop_s;

    logic [BURST_W-1:0]    burst_r, burst_next_s;
    logic [GAP_W-1:0]      gap_r, gap_next_s;

    logic                  accept_s, pop_en_s;
    logic [2:0]            err_inc_s;
    logic [16:0]           err_sum_s;

    logic [31:0]           data_o_r;
    logic [3:0]            be_o_r;
    logic                  data_oe_r, rxf_n_r, txe_n_r, inj_ready_r, cap_valid_r;
    logic [15:0]           err_r;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_next_s;
    end

    // FSM next state; a write strobe in IDLE takes precedence over a read request
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!ft.ft_wr_n)                     state_next_s = IDLE;
                else if (!ft.ft_oe_n && !rxf_n_r)    state_next_s = RD_TA;
                else                                 state_next_s = IDLE;
            end
            RD_TA:   state_next_s = READ;
            READ: begin
                if (ft.ft_oe_n) state_next_s = IDLE;
                else            state_next_s = READ;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM outputs: write acceptance, pop enable and per-cycle violation tally
    always_comb begin
        accept_s  = !ft.ft_wr_n && !txe_n_r && (state_r == IDLE);
        pop_en_s  = !ft.ft_rd_n && (state_r == READ);
        err_inc_s = {2'b00, (!ft.ft_wr_n && txe_n_r)}
                  + {2'b00, (!ft.ft_wr_n && (state_r != IDLE))}
                  + {2'b00, (!ft.ft_wr_n && !ft.ft_oe_n && (state_r == IDLE))}
                  + {2'b00, (!ft.ft_rd_n && ((state_r == IDLE) || (state_r == RD_TA)))};
    end

    // Buffer bookkeeping and head lookahead; a word pushed into an empty slot is bypassed to the head
    always_comb begin
        rx_push_s        = inj_valid && inj_ready_r;
        rx_pop_s         = pop_en_s && (rx_count_r != {CNT_W{1'b0}});
        rx_count_next_s  = rx_count_r + CNT_W'(rx_push_s) - CNT_W'(rx_pop_s);
        rx_rd_ptr_next_s = rx_pop_s ? (rx_rd_ptr_r + DEPTH_LOG2'(1)) : rx_rd_ptr_r;
        if (rx_push_s && (rx_wr_ptr_r == rx_rd_ptr_next_s)) rx_head_next_s = inj_data;
        else                                                rx_head_next_s = rx_mem_r[rx_rd_ptr_next_s];
        tx_push_s        = accept_s;
        tx_pop_s         = cap_valid_r && cap_ready;
        tx_count_next_s  = tx_count_r + CNT_W'(tx_push_s) - CNT_W'(tx_pop_s);
        err_sum_s        = {1'b0, err_r} + {14'b0, err_inc_s};
    end

    // Burst and forced-gap counters for the write side
    always_comb begin
        burst_next_s = burst_r;
        gap_next_s   = gap_r;
        if (gap_r != {GAP_W{1'b0}}) gap_next_s = gap_r - GAP_W'(1);
        else                        gap_next_s = gap_r;
        if (accept_s) begin
            if (burst_r == BURST_W'(TX_BURST - 1)) begin
                burst_next_s = {BURST_W{1'b0}};
                gap_next_s   = GAP_W'(TX_GAP);
            end else begin
                burst_next_s = burst_r + BURST_W'(1);
            end
        end else begin
            burst_next_s = burst_r;
        end
    end

    // Buffer storage; contents need no reset because pointers and counts define validity
    always_ff @(posedge clk) begin
        if (rx_push_s) rx_mem_r[rx_wr_ptr_r] <= inj_data;
        if (tx_push_s) tx_mem_r[tx_wr_ptr_r] <= {ft.ft_be_i, ft.ft_data_i};
    end

    // Pointers, counters, registered bus flags and error counter
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wr_ptr_r <= '0;
            rx_rd_ptr_r <= '0;
            rx_count_r  <= '0;
            tx_wr_ptr_r <= '0;
            tx_rd_ptr_r <= '0;
            tx_count_r  <= '0;
            burst_r     <= '0;
            gap_r       <= '0;
            data_o_r    <= 32'h0;
            be_o_r      <= 4'h0;
            data_oe_r   <= 1'b0;
            rxf_n_r     <= 1'b1;
            txe_n_r     <= 1'b1;
            inj_ready_r <= 1'b0;
            cap_valid_r <= 1'b0;
            err_r       <= 16'h0;
        end else begin
            if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + DEPTH_LOG2'(1);
            if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + DEPTH_LOG2'(1);
            if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + DEPTH_LOG2'(1);
            rx_rd_ptr_r <= rx_rd_ptr_next_s;
            rx_count_r  <= rx_count_next_s;
            tx_count_r  <= tx_count_next_s;
            burst_r     <= burst_next_s;
            gap_r       <= gap_next_s;
            // Hold the last presented word once the RX buffer drains
            if ((state_next_s != IDLE) && (rx_count_next_s != {CNT_W{1'b0}})) data_o_r <= rx_head_next_s;
            be_o_r      <= (state_next_s != IDLE) ? 4'hF : 4'h0;
            data_oe_r   <= (state_next_s != IDLE);
            rxf_n_r     <= (rx_count_next_s == {CNT_W{1'b0}});
            txe_n_r     <= (tx_count_next_s == CNT_W'(DEPTH)) || (gap_next_s != {GAP_W{1'b0}});
            inj_ready_r <= (rx_count_next_s != CNT_W'(DEPTH));
            cap_valid_r <= (tx_count_next_s != {CNT_W{1'b0}});
            err_r       <= err_sum_s[16] ? 16'hFFFF : err_sum_s[15:0];
        end
    end

    assign ft.ft_data_o  = data_o_r;
    assign ft.ft_be_o    = be_o_r;
    assign ft.ft_data_oe = data_oe_r;
    assign ft.ft_rxf_n   = rxf_n_r;
    assign ft.ft_txe_n   = txe_n_r;
    assign inj_ready     = inj_ready_r;
    assign cap_valid     = cap_valid_r;
    assign cap_data      = tx_mem_r[tx_rd_ptr_r];
    assign err_cnt       = err_r;
endmodule
